// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// ---------------------------------------------------------------------------
// SPI master for the single-port SPI slave/RAM subsystem. Takes 10-bit slave
// commands from a parallel valid/ready port, shifts them out MSB first on
// SS_n/MOSI (one bit per clk), and for read-data frames (op 11) captures the
// 8-bit reply from MISO and returns it on the response port.
//
// Frame on the wire (cycle 1 = first cycle after the acceptance edge):
//   START : 1 cycle,  SS_n=0, MOSI=cmd[9] (select bit checked by the slave)
//   SHIFT : 10 cycles, MOSI = cmd[9] .. cmd[0]
//   WAIT  : RD_WAIT cycles, MOSI=0          (read-data frames only)
//   READ  : 8 cycles, MISO sampled MSB first (read-data frames only)
//   GAP   : GAP cycles with SS_n=1, then back to IDLE
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake, cmd_data[9:8]=op, [7:0]=addr/data
//   rsp_valid/data    one-cycle pulse carrying the byte read by op 11
//   busy              frame in progress (START through last GAP cycle)
//   SS_n, MOSI, MISO  SPI pins
//   dbg_state         current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only while idle and drops the cycle
// after a transfer; cmd_data is copied at the transfer edge, so the
// requester may change it afterwards. cmd_valid seen while busy is ignored.
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] shift_q;
    logic       op_rd_q;
    logic [7:0] rx_shift;
    logic       accept;

    assign accept    = cmd_valid && cmd_ready && (state_q == S_IDLE);
    assign dbg_state = state_q;

    // Next-state and per-state cycle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_START;
            end
            S_START: begin
                state_d = S_SHIFT;
                cnt_d   = 4'd0;
            end
            S_SHIFT: begin
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = op_rd_q ? S_WAIT : S_GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_READ: begin
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register plus registered outputs. Outputs are decoded from
    // state_d so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 10'd0;
            op_rd_q   <= 1'b0;
            rx_shift  <= 8'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_ready <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            SS_n      <= !(state_d inside {S_START, S_SHIFT, S_WAIT, S_READ});
            rsp_valid <= 1'b0;
            MOSI      <= 1'b0;

            if (accept) begin
                shift_q <= cmd_data;
                op_rd_q <= &cmd_data[9:8];
                MOSI    <= cmd_data[9];
            end

            // Entry into SHIFT (from START) re-sends cmd[9]; each later SHIFT
            // cycle presents the next bit down.
            if (state_d == S_SHIFT) begin
                MOSI    <= shift_q[9];
                shift_q <= {shift_q[8:0], 1'b0};
            end

            if (state_q == S_READ) begin
                rx_shift <= {rx_shift[6:0], MISO};
                // The last bit is sampled on the same edge that opens GAP,
                // so the response takes it straight from MISO.
                if (state_d == S_GAP) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= {rx_shift[6:0], MISO};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  localparam int RDW0 = 2, GAP0 = 1;
  localparam int RDW1 = 4, GAP1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       cmd_valid [2];
  logic [9:0] cmd_data  [2];
  logic       cmd_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic       ss_n      [2];
  logic       mosi      [2];
  logic       miso      [2];
  logic [2:0] dbg_state [2];

  spi_master_ctrl #(.RD_WAIT(RDW0), .GAP(GAP0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]),
    .cmd_ready(cmd_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]),
    .dbg_state(dbg_state[0])
  );

  spi_master_ctrl #(.RD_WAIT(RDW1), .GAP(GAP1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]),
    .cmd_ready(cmd_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave/RAM environment + frame monitor ----------------
  int         mon_cnt   [2];
  logic [10:0] mon_bits [2];
  int         last_len  [2];
  logic [10:0] last_bits[2];
  int         frames    [2];
  logic [7:0] s_mem [2][256];
  logic [7:0] s_wa [2], s_ra [2], s_reply [2];
  bit         s_rd [2];

  task automatic slave_step(input int i, input int rdw);
    int first;
    logic [9:0] c;
    first = 12 + rdw;
    if (ss_n[i] == 1'b0) begin
      mon_cnt[i]++;
      if (mon_cnt[i] <= 11) mon_bits[i] = {mon_bits[i][9:0], mosi[i]};
      if (mon_cnt[i] == 3) begin
        s_rd[i]    = (mon_bits[i][1:0] == 2'b11);
        s_reply[i] = s_mem[i][s_ra[i]];
      end
      if (s_rd[i] && mon_cnt[i] >= first && mon_cnt[i] < first + 8)
        miso[i] = s_reply[i][7 - (mon_cnt[i] - first)];
      else
        miso[i] = 1'($urandom_range(0, 1));
    end else begin
      if (mon_cnt[i] > 0) begin
        last_len[i]  = mon_cnt[i];
        last_bits[i] = mon_bits[i];
        frames[i]++;
        if (mon_cnt[i] >= 11) begin
          c = mon_bits[i][9:0];
          case (c[9:8])
            2'b00: s_wa[i] = c[7:0];
            2'b01: s_mem[i][s_wa[i]] = c[7:0];
            2'b10: s_ra[i] = c[7:0];
            default: ;
          endcase
        end
      end
      mon_cnt[i]  = 0;
      mon_bits[i] = '0;
      s_rd[i]     = 1'b0;
      miso[i]     = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin
    slave_step(0, RDW0);
    slave_step(1, RDW1);
  end

  // ---------------- reference model + response scoreboard ----------------
  logic [7:0] r_mem [256];
  logic [7:0] r_wa, r_ra;
  logic [7:0] exp_q[$];
  int         rsp_cnt [2];
  logic [7:0] last_rsp1;

  task automatic ref_apply(input logic [9:0] c, output int len, output logic [10:0] bits,
                           output bit rv, output logic [7:0] rd);
    bits = {c[9], c};
    len  = 11;
    rv   = 1'b0;
    rd   = 8'h00;
    case (c[9:8])
      2'b00: r_wa = c[7:0];
      2'b01: r_mem[r_wa] = c[7:0];
      2'b10: r_ra = c[7:0];
      default: begin
        rv  = 1'b1;
        rd  = r_mem[r_ra];
        len = 11 + RDW0 + 8;
        exp_q.push_back(rd);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) begin
      rsp_cnt[0]++;
      if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_data[0]), 32'hFFFF_FFFF);
      else check("rsp_data", 32'(rsp_data[0]), 32'(exp_q.pop_front()));
    end
    if (rsp_valid[1] === 1'b1) begin
      rsp_cnt[1]++;
      last_rsp1 = rsp_data[1];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int i, input logic [9:0] c, input bit hold);
    int g;
    g = 0;
    cmd_valid[i] = 1'b1;
    cmd_data[i]  = c;
    while (cmd_ready[i] !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      check("accept_timeout", 32'(g), 32'd0);
      cmd_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid[i] = 1'b0;
    cmd_data[i] = 10'($urandom_range(0, 1023));
  endtask

  // Called just after an acceptance edge: counts SS_n-low cycles, then the
  // SS_n-high cycles before cmd_ready returns.
  task automatic measure_frame(input int i, output int low, output int hi);
    int g;
    low = 0; hi = 0; g = 0;
    forever begin
      @(negedge clk);
      if (ss_n[i] === 1'b1) break;
      low++; g++;
      if (g > 100) begin low = -1; hi = -1; return; end
    end
    if (cmd_ready[i] === 1'b1) return;
    hi = 1; g = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready[i] === 1'b1) break;
      hi++; g++;
      if (g > 50) begin hi = -1; return; end
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [9:0]  cmd;
    int          len;
    logic [10:0] bits;
    bit          rv;
    logic [7:0]  rsp;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi, len, f0, r0, viol, g;
    logic [10:0] bits;
    logic [7:0]  rd;
    logic [9:0]  c;
    bit          rv;

    vecs[0] = '{10'h300, 21, 11'h700, 1'b1, 8'hA5};
    vecs[1] = '{10'h0AB, 11, 11'h0AB, 1'b0, 8'h00};
    vecs[2] = '{10'h1C3, 11, 11'h1C3, 1'b0, 8'h00};
    vecs[3] = '{10'h2AB, 11, 11'h6AB, 1'b0, 8'h00};
    vecs[4] = '{10'h300, 21, 11'h700, 1'b1, 8'hC3};
    vecs[5] = '{10'h300, 21, 11'h700, 1'b1, 8'hC3};
    vecs[6] = '{10'h2FF, 11, 11'h6FF, 1'b0, 8'h00};
    vecs[7] = '{10'h3FF, 21, 11'h7FF, 1'b1, 8'h5A};

    for (int j = 0; j < 256; j++) begin
      s_mem[0][j] = 8'(j) ^ 8'hA5;
      s_mem[1][j] = 8'(j) ^ 8'hA5;
      r_mem[j]    = 8'(j) ^ 8'hA5;
    end
    for (int k = 0; k < 2; k++) begin
      s_wa[k] = 0; s_ra[k] = 0; mon_cnt[k] = 0; mon_bits[k] = 0; frames[k] = 0;
      rsp_cnt[k] = 0; cmd_valid[k] = 0; cmd_data[k] = 0; miso[k] = 0; s_rd[k] = 0;
    end
    r_wa = 0; r_ra = 0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ss_n", 32'(ss_n[k]), 32'd1);
      check("rst_mosi", 32'(mosi[k]), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_rsp_data", 32'(rsp_data[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready[0]), 32'd1);
    @(negedge clk);

    // table-driven vectors
    for (int v = 0; v < 8; v++) begin
      r0 = rsp_cnt[0];
      ref_apply(vecs[v].cmd, len, bits, rv, rd);
      send_cmd(0, vecs[v].cmd, 1'b0);
      measure_frame(0, lo, hi);
      check("vec_len", 32'(lo), 32'(vecs[v].len));
      check("vec_gap", 32'(hi), 32'(GAP0));
      check("vec_mosi", 32'(last_bits[0]), 32'(vecs[v].bits));
      check("vec_rsp_cnt", 32'(rsp_cnt[0] - r0), 32'(vecs[v].rv));
      if (vecs[v].rv) check("vec_rsp", 32'(rsp_data[0]), 32'(vecs[v].rsp));
    end

    // back-to-back with cmd_valid held
    f0 = frames[0];
    for (int v = 0; v < 4; v++) begin
      c = (v == 0) ? 10'h010 : (v == 1) ? 10'h15A : (v == 2) ? 10'h210 : 10'h300;
      ref_apply(c, len, bits, rv, rd);
      send_cmd(0, c, 1'b1);
      measure_frame(0, lo, hi);
      check("b2b_len", 32'(lo), 32'(len));
      check("b2b_gap", 32'(hi), 32'(GAP0));
      check("b2b_mosi", 32'(last_bits[0]), 32'(bits));
    end
    cmd_valid[0] = 1'b0;
    check("b2b_frames", 32'(frames[0] - f0), 32'd4);
    check("b2b_final_rsp", 32'(rsp_data[0]), 32'h5A);

    // backpressure: cmd_valid held, cmd_data churning mid-frame
    f0 = frames[0];
    ref_apply(10'h0AB, len, bits, rv, rd);
    send_cmd(0, 10'h0AB, 1'b1);
    viol = 0; g = 0;
    while (g < 100) begin
      @(negedge clk);
      if (busy[0] !== 1'b1) break;
      if (cmd_ready[0] !== 1'b0) viol++;
      cmd_data[0] = 10'($urandom_range(0, 1023));
      g++;
    end
    cmd_valid[0] = 1'b0;
    check("bp_timeout", 32'(g < 100), 32'd1);
    check("bp_ready_while_busy", 32'(viol), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_frames", 32'(frames[0] - f0), 32'd1);
    check("bp_mosi", 32'(last_bits[0]), 32'(bits));
    check("bp_len", 32'(last_len[0]), 32'd11);
    check("bp_idle", 32'(busy[0]), 32'd0);

    // parameter sweep instance
    send_cmd(1, 10'h300, 1'b0);
    measure_frame(1, lo, hi);
    check("sweep_len", 32'(lo), 32'd23);
    check("sweep_gap", 32'(hi), 32'(GAP1));
    check("sweep_rsp_cnt", 32'(rsp_cnt[1]), 32'd1);
    check("sweep_rsp", 32'(last_rsp1), 32'hA5);

    // reset during READ cycle 4 of a read-data frame
    @(negedge clk);
    r0 = rsp_cnt[0];
    send_cmd(0, 10'h300, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    check("abort_pre_ss_n", 32'(ss_n[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ss_n", 32'(ss_n[0]), 32'd1);
    check("abort_mosi", 32'(mosi[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_rsp_data", 32'(rsp_data[0]), 32'd0);
    check("abort_ready", 32'(cmd_ready[0]), 32'd0);
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = 10'h0AB;
    @(posedge clk); #1;
    check("rst_vs_cmd_busy", 32'(busy[0]), 32'd0);
    check("rst_vs_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready[0]), 32'd1);
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    ref_apply(10'h0AB, len, bits, rv, rd);
    send_cmd(0, 10'h0AB, 1'b0);
    measure_frame(0, lo, hi);
    check("post_rst_len", 32'(lo), 32'd11);
    check("post_rst_mosi", 32'(last_bits[0]), 32'h0AB);
    check("abort_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);

    // randomized commands against the reference model
    for (int n = 0; n < 25; n++) begin
      c = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      ref_apply(c, len, bits, rv, rd);
      send_cmd(0, c, 1'b0);
      measure_frame(0, lo, hi);
      check("rnd_len", 32'(lo), 32'(len));
      check("rnd_gap", 32'(hi), 32'(GAP0));
      check("rnd_mosi", 32'(last_bits[0]), 32'(bits));
    end

    repeat (4) @(negedge clk);
    check("rsp_left_over", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
